// File: rtl/registers_pkg.sv
// Shared definitions for the parallel-load register family: state encoding and counter sizing.
package registers_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SHIFT  = ST_SHIFT,
    S_PARITY = ST_PARITY
  } state_e;

  // Wide enough to count 0..N.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit index counter for the PISO register; last flags the final data bit of a word.
module piso_bit_counter
  import registers_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [cnt_w(N)-1:0]   cnt,
  output logic                  last
);

  localparam int CNT_W = cnt_w(N);

  assign last = (cnt == CNT_W'(N - 1));

  // Wraps to zero on the final bit so the counter idles at zero between words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out register, LSB first, with ready/done handshake and shift_en stall.
// Define PARITY_EN to append an even-parity bit after the N data bits.
module piso_shift_register
  import registers_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] din,
  input  logic         shift_en,
  output logic         ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         done
);

  localparam int CNT_W = cnt_w(N);

  state_e           state_q, state_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic             done_q, done_d;
  logic             load_acc, shift_acc, last;
  logic [CNT_W-1:0] cnt;
`ifdef PARITY_EN
  logic             par_q, par_d;
`endif

  piso_bit_counter #(.N(N)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (load_acc),
    .inc  (shift_acc),
    .cnt  (cnt),
    .last (last)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    done_d     = 1'b0;
    ready      = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    load_acc   = 1'b0;
    shift_acc  = 1'b0;
`ifdef PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (load) begin
          load_acc = 1'b1;
          shreg_d  = din;
          state_d  = S_SHIFT;
`ifdef PARITY_EN
          par_d    = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        sout       = shreg_q[0];
        sout_valid = 1'b1;
        if (shift_en) begin
          shift_acc = 1'b1;
          shreg_d   = shreg_q >> 1;
`ifdef PARITY_EN
          par_d     = par_q ^ shreg_q[0];
          if (last) state_d = S_PARITY;
`else
          if (last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
`endif
        end
      end
`ifdef PARITY_EN
      S_PARITY: begin
        sout       = par_q;
        sout_valid = 1'b1;
        if (shift_en) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      done_q  <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign done = done_q;

  // The bit index must never run past the last data bit while shifting.
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_SHIFT) |-> (cnt <= CNT_W'(N - 1)));

endmodule

// File: tb/tb_piso_shift_register.sv
// Table-driven bench for piso_shift_register (N=8) plus hand sequences for reset corners.
module tb_piso_shift_register;

  logic       clk = 1'b0;
  logic       rst_n, load, shift_en;
  logic [7:0] din;
  logic       ready, sout, sout_valid, done;

  int n_checks = 0;
  int n_fail   = 0;

  piso_shift_register #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .din       (din),
    .shift_en  (shift_en),
    .ready     (ready),
    .sout      (sout),
    .sout_valid(sout_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Inputs are applied at the coming posedge; expectations are the outputs seen before it.
  typedef struct {
    logic       ld;
    logic [7:0] d;
    logic       se;
    logic       e_ready;
    logic       e_sout;
    logic       e_valid;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic ld, input logic [7:0] d, input logic se,
                              input logic rdy, input logic so, input logic vld, input logic dn);
    vec_t v;
    v.ld = ld; v.d = d; v.se = se;
    v.e_ready = rdy; v.e_sout = so; v.e_valid = vld; v.e_done = dn;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic r, input logic s,
                           input logic v, input logic d);
    check({tag, ".ready"}, idx, ready, r);
    check({tag, ".sout"}, idx, sout, s);
    check({tag, ".sout_valid"}, idx, sout_valid, v);
    check({tag, ".done"}, idx, done, d);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; din = 8'h00; shift_en = 1'b0;

    // Reset held for two cycles
    @(negedge clk);
    @(negedge clk);
    check_all("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("reset: ready=%b sout=%b sout_valid=%b done=%b", ready, sout, sout_valid, done);
    rst_n = 1'b1;

    // Idle after release
    add(0, 8'h00, 0, 1, 0, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0, 0);
    // A5 with shift_en held: 1,0,1,0,0,1,0,1 then done
    add(1, 8'hA5, 1, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 1, 0, 0, 1);
    add(0, 8'h00, 1, 1, 0, 0, 0);
    // A5 with a 3-cycle stall after the 2nd bit
    add(1, 8'hA5, 1, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 0, 1, 0, 0, 1);
    add(0, 8'h00, 0, 1, 0, 0, 0);
    // A5 with an FF load mid-word (ignored), final-accept load (ignored), 3C on the done cycle
    add(1, 8'hA5, 1, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(1, 8'hFF, 1, 0, 1, 1, 0);
    add(1, 8'hFF, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(1, 8'h5A, 1, 0, 1, 1, 0);
    add(1, 8'h3C, 1, 1, 0, 0, 1);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 1, 0, 0, 1);
    add(0, 8'h00, 1, 1, 0, 0, 0);
`ifdef PARITY_EN
    // 07: 1,1,1,0,0,0,0,0 then parity 1
    add(1, 8'h07, 1, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 1, 0, 0, 1);
    // 03: 1,1,0,0,0,0,0,0 then parity 0
    add(1, 8'h03, 1, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 1, 0, 0, 1);
    add(0, 8'h00, 0, 1, 0, 0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      check_all("vec", i, vecs[i].e_ready, vecs[i].e_sout, vecs[i].e_valid, vecs[i].e_done);
      $display("vec %0d: load=%b din=%h shift_en=%b -> ready=%b sout=%b sout_valid=%b done=%b",
               i, vecs[i].ld, vecs[i].d, vecs[i].se, ready, sout, sout_valid, done);
      load     = vecs[i].ld;
      din      = vecs[i].d;
      shift_en = vecs[i].se;
    end

    // Asynchronous reset during the 4th bit of A5
    @(negedge clk);
    load = 1'b1; din = 8'hA5; shift_en = 1'b1;
    @(negedge clk);
    load = 1'b0; din = 8'h00;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_all("midword", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("async reset mid-word: ready=%b sout=%b sout_valid=%b done=%b",
             ready, sout, sout_valid, done);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_all("post_rst", i, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    $display("post-reset idle window: %0d cycles checked", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
